// File: rtl/cpu16_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cpu16_pkg
// Brief  : Shared widths, fetch-state encoding and halt opcode for the CPU16.
// Rev    : 1.0
// ============================================================================
package cpu16_pkg;

    localparam int          INSTR_W             = 16;
    localparam int          BYTE_W              = 8;
    localparam logic [15:0] PC_STEP             = 16'd2;
    localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

    localparam logic [2:0] FS_BOOT     = 3'd0;
    localparam logic [2:0] FS_FETCH_HI = 3'd1;
    localparam logic [2:0] FS_FETCH_LO = 3'd2;
    localparam logic [2:0] FS_ISSUE    = 3'd3;
    localparam logic [2:0] FS_HALT     = 3'd4;
    localparam logic [2:0] FS_FAULT    = 3'd5;

    typedef enum logic [2:0] {
        ST_BOOT     = FS_BOOT,
        ST_FETCH_HI = FS_FETCH_HI,
        ST_FETCH_LO = FS_FETCH_LO,
        ST_ISSUE    = FS_ISSUE,
        ST_HALT     = FS_HALT,
        ST_FAULT    = FS_FAULT
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_byte_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : instr_byte_assembler
// Brief  : Instruction register built from separately loaded hi/lo bytes.
// Rev    : 1.0
// ============================================================================
module instr_byte_assembler
    import cpu16_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               i_clear,
    input  wire logic               i_load_hi,
    input  wire logic               i_load_lo,
    input  wire logic [BYTE_W-1:0]  i_byte,
    output logic      [INSTR_W-1:0] o_instr
);

    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_instr <= '0;
        end else begin
            if (i_load_hi) r_instr[INSTR_W-1:BYTE_W] <= i_byte;
            if (i_load_lo) r_instr[BYTE_W-1:0]       <= i_byte;
        end
    end

    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : instruction_fetch
// Brief  : PC owner; fetches 16-bit instructions as two byte reads, hi first.
// Rev    : 1.0
// ============================================================================
module instruction_fetch
    import cpu16_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  wire logic        Clock,
    input  wire logic        ResetN,
    output logic             MemReq,
    output logic [15:0]      MemAddr,
    input  wire logic        MemReady,
    input  wire logic [7:0]  MemData,
    output logic [15:0]      PC,
    output logic [15:0]      Instruction,
    output logic             InstrValid,
    input  wire logic        Retire,
    input  wire logic        Stall,
    input  wire logic [15:0] PcNext,
    output logic             Halted,
    output logic             AlignFault
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [15:0]  r_pc;
    logic [15:0]  w_pc_next;
    logic         w_load_hi;
    logic         w_load_lo;

    instr_byte_assembler u_asm (
        .clk       (Clock),
        .i_clear   (~ResetN),
        .i_load_hi (w_load_hi),
        .i_load_lo (w_load_lo),
        .i_byte    (MemData),
        .o_instr   (Instruction)
    );

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load_hi    = 1'b0;
        w_load_lo    = 1'b0;
        MemReq       = 1'b0;
        MemAddr      = r_pc;
        InstrValid   = 1'b0;
        Halted       = 1'b0;
        AlignFault   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_FETCH_HI;
            end
            ST_FETCH_HI: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    w_load_hi    = 1'b1;
                    w_state_next = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                // PC is always even here, so +1 is just setting bit 0
                MemReq  = 1'b1;
                MemAddr = {r_pc[15:1], 1'b1};
                if (MemReady) begin
                    w_load_lo    = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                InstrValid = 1'b1;
                if (Instruction[15:12] == HALT_OPCODE) begin
                    w_state_next = ST_HALT;
                end else if (Retire && !Stall) begin
                    w_pc_next    = PcNext;
                    w_state_next = PcNext[0] ? ST_FAULT : ST_FETCH_HI;
                end
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            ST_FAULT: begin
                AlignFault = 1'b1;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    assign PC = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_instruction_fetch
// Brief  : Directed plus randomized checking against a byte-count fetch model.
// Rev    : 1.0
// ============================================================================
module tb_instruction_fetch;
    import cpu16_pkg::*;

    localparam logic [15:0] C_RESET_PC = 16'h0000;
    localparam logic [3:0]  C_HALT     = 4'hF;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemReady;
    logic [7:0]  MemData;
    logic [15:0] PC;
    logic [15:0] Instruction;
    logic        InstrValid;
    logic        Retire;
    logic        Stall;
    logic [15:0] PcNext;
    logic        Halted;
    logic        AlignFault;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bytes received for the current instruction (0..2)
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    int          m_nb;
    bit          m_boot, m_halt, m_fault;

    instruction_fetch #(.RESET_PC(C_RESET_PC), .HALT_OPCODE(C_HALT)) dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemReady    (MemReady),
        .MemData     (MemData),
        .PC          (PC),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .Retire      (Retire),
        .Stall       (Stall),
        .PcNext      (PcNext),
        .Halted      (Halted),
        .AlignFault  (AlignFault)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (!ResetN) begin
            m_pc = C_RESET_PC; m_instr = 16'h0000; m_nb = 0;
            m_boot = 1; m_halt = 0; m_fault = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt || m_fault) begin
            // terminal until reset
        end else if (m_nb < 2) begin
            if (MemReady) begin
                if (m_nb == 0) m_instr[15:8] = MemData;
                else           m_instr[7:0]  = MemData;
                m_nb++;
            end
        end else if (m_instr[15:12] == C_HALT) begin
            m_halt = 1;
        end else if (Retire && !Stall) begin
            m_pc = PcNext;
            m_nb = 0;
            if (PcNext[0]) m_fault = 1;
        end
    endtask

    task automatic check_all();
        logic        e_req, e_valid;
        logic [15:0] e_addr;
        e_req   = !m_boot && !m_halt && !m_fault && (m_nb < 2);
        e_valid = !m_boot && !m_halt && !m_fault && (m_nb == 2);
        e_addr  = (e_req && m_nb == 1) ? m_pc + 16'd1 : m_pc;
        chk("MemReq",      {15'd0, MemReq},     {15'd0, e_req});
        chk("MemAddr",     MemAddr,             e_addr);
        chk("PC",          PC,                  m_pc);
        chk("Instruction", Instruction,         m_instr);
        chk("InstrValid",  {15'd0, InstrValid}, {15'd0, e_valid});
        chk("Halted",      {15'd0, Halted},     {15'd0, m_halt});
        chk("AlignFault",  {15'd0, AlignFault}, {15'd0, m_fault});
    endtask

    // Called at a negedge: drive, take the rising edge, then compare
    task automatic cycle(input logic rstn, input logic rdy, input logic [7:0] data,
                         input logic ret, input logic stl, input logic [15:0] pcn);
        ResetN = rstn; MemReady = rdy; MemData = data;
        Retire = ret;  Stall = stl;    PcNext = pcn;
        @(posedge Clock);
        model_update();
        @(negedge Clock);
        check_all();
    endtask

    task automatic fetch_pair(input logic [7:0] hi, input logic [7:0] lo);
        cycle(1, 1, hi, 0, 0, 16'h0);
        cycle(1, 1, lo, 0, 0, 16'h0);
    endtask

    initial begin
        ResetN = 0; MemReady = 0; MemData = 0; Retire = 0; Stall = 0; PcNext = 0;
        m_pc = 16'hxxxx; m_instr = 16'hxxxx; m_nb = 0;
        m_boot = 1; m_halt = 0; m_fault = 0;
        @(negedge Clock);
        cycle(0, 1, 8'hAA, 1, 0, 16'h0);
        cycle(0, 0, 8'h00, 0, 0, 16'h0);

        // Boot then first instruction 0x1234 from zero-wait memory
        cycle(1, 1, 8'h55, 0, 0, 16'h0);
        fetch_pair(8'h12, 8'h34);
        chk("first_instr", Instruction, 16'h1234);
        chk("first_valid", {15'd0, InstrValid}, 16'd1);

        // Wait states during the low-byte read
        cycle(1, 1, 8'h00, 1, 0, 16'h0002);
        cycle(1, 1, 8'h56, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 8'($urandom), 0, 0, 16'h0);
            chk("wait_addr", MemAddr, 16'h0003);
        end
        cycle(1, 1, 8'h78, 0, 0, 16'h0);

        // Stall overrides Retire
        cycle(1, 1, 8'h00, 1, 1, 16'h0010);
        cycle(1, 1, 8'h00, 1, 1, 16'h0010);
        chk("stall_pc", PC, 16'h0002);
        cycle(1, 1, 8'h00, 1, 0, 16'h0010);
        chk("post_stall_addr", MemAddr, 16'h0010);
        fetch_pair(8'hAB, 8'hCD);

        // Address wrap from the top of memory
        cycle(1, 1, 8'h00, 1, 0, 16'hFFFE);
        fetch_pair(8'h01, 8'h02);
        cycle(1, 1, 8'h00, 1, 0, 16'h0000);
        fetch_pair(8'h03, 8'h04);

        // Misaligned target
        cycle(1, 1, 8'h00, 1, 0, 16'h0007);
        for (int i = 0; i < 4; i++) cycle(1, 1, 8'($urandom), 1, 0, 16'h0020);
        chk("fault_pc", PC, 16'h0007);

        // Halt opcode
        cycle(0, 0, 8'h00, 0, 0, 16'h0);
        cycle(1, 1, 8'h00, 0, 0, 16'h0);
        fetch_pair(8'hF0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1, 1, 8'($urandom), 1, 0, 16'h0040);
        chk("halted", {15'd0, Halted}, 16'd1);

        // Reset mid-handshake in the high-byte read
        cycle(0, 0, 8'h00, 0, 0, 16'h0);
        cycle(1, 0, 8'h00, 0, 0, 16'h0);
        cycle(1, 0, 8'h00, 0, 0, 16'h0);
        cycle(0, 0, 8'h00, 0, 0, 16'h0);
        chk("rst_memreq", {15'd0, MemReq}, 16'd0);
        cycle(1, 1, 8'h00, 0, 0, 16'h0);
        fetch_pair(8'h22, 8'h33);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] pcn;
            pcn = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 29) == 0) pcn[0] = 1'b1;
            if ($urandom_range(0, 19) == 0) pcn = 16'hFFFE;
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), pcn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
